// File: rtl/vram_slot_arbiter_if.sv
// vram_slot_arbiter_if
//   Bundles the requester and VRAM-side signals of the VRAM slot arbiter.
//   slave  : the arbiter's view (requests and memory read data in,
//            grants, acks, read-valid strobes and the VRAM bus out).
//   master : the environment's view (requesters plus the VRAM macro).
//
//   bgAddr    background fetch address, used while bgGrant is high
//   bgGrant   VRAM is driven by bgAddr this cycle
//   sprReq    sprite read request; sprAddr its address
//   sprAck    sprite access issued this cycle
//   sprRValid memRData holds sprite data
//   cpuReq    CPU request; cpuWe/cpuAddr/cpuWData describe the access
//   cpuAck    CPU access issued this cycle
//   cpuRValid memRData holds CPU read data
//   memAddr   VRAM address
//   memWe     VRAM write enable
//   memWData  VRAM write data
//   memRData  VRAM read data, one cycle after the address
interface vram_slot_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] bgAddr;
  logic              bgGrant;

  logic              sprReq;
  logic [ADDR_W-1:0] sprAddr;
  logic              sprAck;
  logic              sprRValid;

  logic              cpuReq;
  logic              cpuWe;
  logic [ADDR_W-1:0] cpuAddr;
  logic [DATA_W-1:0] cpuWData;
  logic              cpuAck;
  logic              cpuRValid;

  logic [ADDR_W-1:0] memAddr;
  logic              memWe;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] memRData;

  modport slave (
    input  bgAddr, sprReq, sprAddr, cpuReq, cpuWe, cpuAddr, cpuWData, memRData,
    output bgGrant, sprAck, sprRValid, cpuAck, cpuRValid, memAddr, memWe, memWData
  );

  modport master (
    output bgAddr, sprReq, sprAddr, cpuReq, cpuWe, cpuAddr, cpuWData, memRData,
    input  bgGrant, sprAck, sprRValid, cpuAck, cpuRValid, memAddr, memWe, memWData
  );

endinterface

// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter
//   Shares a single-port VRAM (1-cycle read latency) between the background
//   fetch pipeline, the sprite fetch unit and the CPU. While a line's fetch
//   window is live, slots 0, 2 and 3 of every 12-cycle tile belong to the
//   background pipeline. Every other cycle is given to the CPU or the sprite
//   unit by round-robin, with a req/ack handshake and a registered
//   read-valid strobe one cycle after the access.
//
//   Ports:
//     clk            video clock
//     reset          synchronous, active-high
//     lineStarting_i one-cycle pulse that (re)starts the background window
//     panOffset_i    fine scroll; nonzero lengthens the window by one tile
//     bus            vram_slot_arbiter_if.slave (requesters + VRAM bus)
//
//   Build option:
//     VRAM_CPU_WRITE_EN  when defined, CPU writes reach the VRAM. When not
//                        defined, memWe/memWData are tied 0 and every CPU
//                        access is treated as a read.
module vram_slot_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lineStarting_i,
  input  logic [3:0]            panOffset_i,
  vram_slot_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BG   = 2'd1,
    OWN_SPR  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_e;

  typedef enum logic {
    RR_SPR = 1'b0,
    RR_CPU = 1'b1
  } rrLast_e;

  localparam logic [6:0]  TILES_PLAIN  = 7'd40;
  localparam logic [6:0]  TILES_PANNED = 7'd41;
  localparam logic [11:0] SLOT_FIRST   = 12'h001;

  logic [11:0] slot_q, slot_d;
  logic [6:0]  tileCount_q, tileCount_d;
  logic        live_q, live_d;
  owner_e      owner_q, owner_d;
  rrLast_e     rrLast_q, rrLast_d;
  logic        cpuRValid_q, cpuRValid_d;
  logic        sprRValid_q, sprRValid_d;

  logic [6:0]  tileLimit;
  logic [6:0]  tileInc;
  logic        bgNext;
  logic        cpuEligible;
  logic        sprEligible;
  logic        cpuIsRead;

  logic [ADDR_W-1:0] addrMux;
  logic              weMux;
  logic [DATA_W-1:0] wdataMux;

  // State register: slot ring, tile counter, window flag, owner and the
  // round-robin memory. Reset returns to an idle bus with the CPU winning
  // the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q      <= '0;
      tileCount_q <= '0;
      live_q      <= 1'b0;
      owner_q     <= OWN_NONE;
      rrLast_q    <= RR_SPR;
      cpuRValid_q <= 1'b0;
      sprRValid_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      tileCount_q <= tileCount_d;
      live_q      <= live_d;
      owner_q     <= owner_d;
      rrLast_q    <= rrLast_d;
      cpuRValid_q <= cpuRValid_d;
      sprRValid_q <= sprRValid_d;
    end
  end

  // Without CPU write support every CPU access is a read.
`ifdef VRAM_CPU_WRITE_EN
  assign cpuIsRead = ~bus.cpuWe;
`else
  assign cpuIsRead = 1'b1;
`endif

  // Next-state logic. The owner for the next cycle is decided now from the
  // next slot position and from the requests seen this cycle, so owner_q is
  // a clean register that drives the bus directly.
  always_comb begin
    slot_d      = slot_q;
    tileCount_d = tileCount_q;
    live_d      = live_q;
    owner_d     = OWN_NONE;
    rrLast_d    = rrLast_q;
    cpuRValid_d = (owner_q == OWN_CPU) && cpuIsRead;
    sprRValid_d = (owner_q == OWN_SPR);

    tileLimit = (panOffset_i != 4'd0) ? TILES_PANNED : TILES_PLAIN;
    tileInc   = tileCount_q + 7'd1;

    if (lineStarting_i) begin
      live_d      = 1'b1;
      slot_d      = SLOT_FIRST;
      tileCount_d = '0;
    end else if (live_q) begin
      slot_d = {slot_q[10:0], slot_q[11]};
      if (slot_q[11]) begin
        tileCount_d = tileInc;
        // The window closes as the last tile wraps, so every tile,
        // including the final one, sees the same slot pattern.
        if (tileInc == tileLimit) begin
          live_d = 1'b0;
          slot_d = '0;
        end
      end
    end

    bgNext = live_d && (slot_d[0] || slot_d[2] || slot_d[3]);

    // A requester acked this cycle may still hold req; it is not eligible
    // again until the following cycle, which prevents a double issue.
    cpuEligible = bus.cpuReq && (owner_q != OWN_CPU);
    sprEligible = bus.sprReq && (owner_q != OWN_SPR);

    if (bgNext) begin
      owner_d = OWN_BG;
    end else if (cpuEligible && sprEligible) begin
      owner_d = (rrLast_q == RR_SPR) ? OWN_CPU : OWN_SPR;
    end else if (cpuEligible) begin
      owner_d = OWN_CPU;
    end else if (sprEligible) begin
      owner_d = OWN_SPR;
    end

    if (owner_d == OWN_CPU) begin
      rrLast_d = RR_CPU;
    end else if (owner_d == OWN_SPR) begin
      rrLast_d = RR_SPR;
    end
  end

  // VRAM bus mux on the registered owner; an idle cycle drives zeros.
  always_comb begin
    addrMux  = '0;
    weMux    = 1'b0;
    wdataMux = '0;
    unique case (owner_q)
      OWN_BG:  addrMux = bus.bgAddr;
      OWN_SPR: addrMux = bus.sprAddr;
      OWN_CPU: begin
        addrMux = bus.cpuAddr;
`ifdef VRAM_CPU_WRITE_EN
        weMux    = bus.cpuWe;
        wdataMux = bus.cpuWData;
`endif
      end
      default: addrMux = '0;
    endcase
  end

  assign bus.memAddr   = addrMux;
  assign bus.memWe     = weMux;
  assign bus.memWData  = wdataMux;

  assign bus.bgGrant   = (owner_q == OWN_BG);
  assign bus.cpuAck    = (owner_q == OWN_CPU);
  assign bus.sprAck    = (owner_q == OWN_SPR);
  assign bus.cpuRValid = cpuRValid_q;
  assign bus.sprRValid = sprRValid_q;

endmodule
